// File: rtl/rf_pkg.sv
// Shared types and helpers for the bit-enable 1R1W register file.
package rf_pkg;

  typedef enum logic {
    RfInit = 1'b0,
    RfIdle = 1'b1
  } rf_state_e;

  // Upper bound on word width accepted by rf_merge; callers zero-extend and truncate.
  localparam int unsigned RfMaxWidth = 1024;

  function automatic logic [RfMaxWidth-1:0] rf_merge(input logic [RfMaxWidth-1:0] old_word,
                                                     input logic [RfMaxWidth-1:0] new_word,
                                                     input logic [RfMaxWidth-1:0] mask);
    return (old_word & ~mask) | (new_word & mask);
  endfunction

endpackage

// File: rtl/rf_1r1w_be_ctrl_rdpipe.sv
// Read-return pipeline: one stage always, plus an optional output register.
module rf_1r1w_be_ctrl_rdpipe #(
  parameter int unsigned Width  = 32,
  parameter int unsigned OutReg = 0
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             fire_i,
  input  logic [Width-1:0] data_i,
  input  logic             err_i,
  output logic             rvalid_o,
  output logic [Width-1:0] data_o,
  output logic             err_o
);

  logic             s1_valid_q;
  logic [Width-1:0] s1_data_q;
  logic             s1_err_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      s1_valid_q <= 1'b0;
      s1_data_q  <= '0;
      s1_err_q   <= 1'b0;
    end else begin
      s1_valid_q <= fire_i;
      s1_err_q   <= fire_i & err_i;
      if (fire_i) begin
        s1_data_q <= data_i;
      end
    end
  end

  if (OutReg != 0) begin : g_out_reg
    logic             s2_valid_q;
    logic [Width-1:0] s2_data_q;
    logic             s2_err_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
        s2_valid_q <= 1'b0;
        s2_data_q  <= '0;
        s2_err_q   <= 1'b0;
      end else begin
        s2_valid_q <= s1_valid_q;
        s2_err_q   <= s1_valid_q & s1_err_q;
        if (s1_valid_q) begin
          s2_data_q <= s1_data_q;
        end
      end
    end

    assign rvalid_o = s2_valid_q;
    assign data_o   = s2_data_q;
    assign err_o    = s2_err_q;
  end else begin : g_no_out_reg
    assign rvalid_o = s1_valid_q;
    assign data_o   = s1_data_q;
    assign err_o    = s1_err_q;
  end

endmodule

// File: rtl/rf_1r1w_be_ctrl.sv
// Parametrised 1R1W register file with per-bit write masks, write-first bypass,
// out-of-range detection and a zeroization FSM.
module rf_1r1w_be_ctrl
  import rf_pkg::*;
#(
  parameter int unsigned Depth       = 512,
  parameter int unsigned Width       = 32,
  parameter int unsigned OutReg      = 0,
  parameter int unsigned InitOnReset = 1,
  localparam int unsigned AddrW      = $clog2(Depth)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             wr_req_i,
  output logic             wr_gnt_o,
  input  logic [AddrW-1:0] wr_addr_i,
  input  logic [Width-1:0] wr_data_i,
  input  logic [Width-1:0] wr_mask_i,
  input  logic             rd_req_i,
  output logic             rd_gnt_o,
  input  logic [AddrW-1:0] rd_addr_i,
  output logic             rd_rvalid_o,
  output logic [Width-1:0] rd_data_o,
  output logic             rd_err_o,
  input  logic             init_req_i,
  output logic             init_busy_o
);

  localparam logic [AddrW:0]   DepthExt   = (AddrW + 1)'(Depth);
  localparam logic [AddrW-1:0] LastIdx    = AddrW'(Depth - 1);
  localparam rf_state_e        ResetState = (InitOnReset != 0) ? RfInit : RfIdle;

  rf_state_e        state_q, state_d;
  logic [AddrW-1:0] cnt_q, cnt_d;
  logic [Width-1:0] mem_q [Depth];

  logic             idle;
  logic             wr_in_range, rd_in_range;
  logic             wr_fire, rd_fire;
  logic [AddrW-1:0] wr_idx, rd_idx;
  logic [Width-1:0] wr_old, wr_new, rd_raw, rd_word;
  logic             bypass;

  // FSM state register
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= ResetState;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      RfInit: begin
        if (cnt_q == LastIdx) begin
          state_d = RfIdle;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      RfIdle: begin
        if (init_req_i) begin
          state_d = RfInit;
          cnt_d   = '0;
        end
      end
    endcase
  end

  assign idle        = (state_q == RfIdle);
  assign init_busy_o = (state_q == RfInit);

  // Gating with rst_i keeps grants low during reset even when reset lands in IDLE.
  assign wr_gnt_o = idle & wr_req_i & ~rst_i;
  assign rd_gnt_o = idle & rd_req_i & ~rst_i;

  assign wr_in_range = ({1'b0, wr_addr_i} < DepthExt);
  assign rd_in_range = ({1'b0, rd_addr_i} < DepthExt);
  assign wr_fire     = wr_gnt_o & wr_in_range;
  assign rd_fire     = rd_gnt_o;

  // Clamp indices so out-of-range addresses never index past the array.
  assign wr_idx = wr_in_range ? wr_addr_i : '0;
  assign rd_idx = rd_in_range ? rd_addr_i : '0;

  assign wr_old = mem_q[wr_idx];
  assign wr_new = Width'(rf_merge(RfMaxWidth'(wr_old), RfMaxWidth'(wr_data_i),
                                  RfMaxWidth'(wr_mask_i)));
  assign rd_raw = mem_q[rd_idx];
  assign bypass = wr_fire & rd_in_range & (wr_addr_i == rd_addr_i);

  always_comb begin
    rd_word = rd_raw;
    if (!rd_in_range) begin
      rd_word = '0;
    end else if (bypass) begin
      rd_word = wr_new;
    end
  end

  // Zeroization only in INIT and user writes only in IDLE, so the ports never collide.
  always_ff @(posedge clk_i) begin
    if (state_q == RfInit) begin
      mem_q[cnt_q] <= '0;
    end else if (wr_fire) begin
      mem_q[wr_idx] <= wr_new;
    end
  end

  rf_1r1w_be_ctrl_rdpipe #(
    .Width  (Width),
    .OutReg (OutReg)
  ) u_rdpipe (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .fire_i   (rd_fire),
    .data_i   (rd_word),
    .err_i    (~rd_in_range),
    .rvalid_o (rd_rvalid_o),
    .data_o   (rd_data_o),
    .err_o    (rd_err_o)
  );

endmodule

// File: tb/tb_rf_1r1w_be_ctrl.sv
// Directed bench: two instances (512 deep latency 1, 300 deep latency 2) share stimulus.
module tb_rf_1r1w_be_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        wr_req = 1'b0;
  logic [8:0]  wr_addr = '0;
  logic [31:0] wr_data = '0;
  logic [31:0] wr_mask = '0;
  logic        rd_req = 1'b0;
  logic [8:0]  rd_addr = '0;
  logic        init_req = 1'b0;

  logic        wr_gnt0, rd_gnt0, rvalid0, err0, busy0;
  logic [31:0] rdata0;
  logic        wr_gnt1, rd_gnt1, rvalid1, err1, busy1;
  logic [31:0] rdata1;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  rf_1r1w_be_ctrl #(
    .Depth       (512),
    .Width       (32),
    .OutReg      (0),
    .InitOnReset (1)
  ) u_dut0 (
    .clk_i       (clk),
    .rst_i       (rst),
    .wr_req_i    (wr_req),
    .wr_gnt_o    (wr_gnt0),
    .wr_addr_i   (wr_addr),
    .wr_data_i   (wr_data),
    .wr_mask_i   (wr_mask),
    .rd_req_i    (rd_req),
    .rd_gnt_o    (rd_gnt0),
    .rd_addr_i   (rd_addr),
    .rd_rvalid_o (rvalid0),
    .rd_data_o   (rdata0),
    .rd_err_o    (err0),
    .init_req_i  (init_req),
    .init_busy_o (busy0)
  );

  rf_1r1w_be_ctrl #(
    .Depth       (300),
    .Width       (32),
    .OutReg      (1),
    .InitOnReset (1)
  ) u_dut1 (
    .clk_i       (clk),
    .rst_i       (rst),
    .wr_req_i    (wr_req),
    .wr_gnt_o    (wr_gnt1),
    .wr_addr_i   (wr_addr),
    .wr_data_i   (wr_data),
    .wr_mask_i   (wr_mask),
    .rd_req_i    (rd_req),
    .rd_gnt_o    (rd_gnt1),
    .rd_addr_i   (rd_addr),
    .rd_rvalid_o (rvalid1),
    .rd_data_o   (rdata1),
    .rd_err_o    (err1),
    .init_req_i  (init_req),
    .init_busy_o (busy1)
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, " wr_gnt0"}, wr_gnt0, 0);
    check_eq({tag, " rd_gnt0"}, rd_gnt0, 0);
    check_eq({tag, " rvalid0"}, rvalid0, 0);
    check_eq({tag, " rdata0"}, rdata0, 0);
    check_eq({tag, " err0"}, err0, 0);
    check_eq({tag, " busy0"}, busy0, 1);
    check_eq({tag, " rvalid1"}, rvalid1, 0);
    check_eq({tag, " rdata1"}, rdata1, 0);
    check_eq({tag, " err1"}, err1, 0);
    check_eq({tag, " busy1"}, busy1, 1);
  endtask

  // Called just after an edge with INIT already running; counts busy cycles and stray grants.
  task automatic measure_init(input string tag);
    int b0 = 0;
    int b1 = 0;
    int g  = 0;
    wr_req  = 1'b1;
    wr_addr = 9'd511;
    wr_data = 32'hFFFF_FFFF;
    wr_mask = 32'h0;
    rd_req  = 1'b1;
    rd_addr = 9'd0;
    #1;
    for (int c = 0; c < 700; c++) begin
      if (busy0) begin
        b0++;
        if (wr_gnt0 || rd_gnt0) g++;
      end
      if (busy1) begin
        b1++;
        if (wr_gnt1 || rd_gnt1) g++;
      end
      if (!busy0 && !busy1) break;
      @(posedge clk);
      #2;
    end
    wr_req = 1'b0;
    rd_req = 1'b0;
    check_eq({tag, " busy cycles d512"}, b0, 512);
    check_eq({tag, " busy cycles d300"}, b1, 300);
    check_eq({tag, " grants in init"}, g, 0);
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic issue(input bit wr, input logic [8:0] wa, input logic [31:0] wd,
                       input logic [31:0] wm, input bit rd, input logic [8:0] ra);
    wr_req  = wr;
    wr_addr = wa;
    wr_data = wd;
    wr_mask = wm;
    rd_req  = rd;
    rd_addr = ra;
    #1;
    check_eq("wr_gnt0", wr_gnt0, wr);
    check_eq("rd_gnt1", rd_gnt1, rd);
    @(posedge clk);
    #1;
    wr_req = 1'b0;
    rd_req = 1'b0;
  endtask

  // Called at T+1 after a granted read in cycle T.
  task automatic expect_read(input string tag, input logic [31:0] d0, input bit e0,
                             input logic [31:0] d1, input bit e1);
    check_eq({tag, " rvalid0 T+1"}, rvalid0, 1);
    check_eq({tag, " rdata0"}, rdata0, d0);
    check_eq({tag, " err0"}, err0, e0);
    check_eq({tag, " rvalid1 T+1"}, rvalid1, 0);
    @(posedge clk);
    #1;
    check_eq({tag, " rvalid0 T+2"}, rvalid0, 0);
    check_eq({tag, " err0 idle"}, err0, 0);
    check_eq({tag, " rdata0 hold"}, rdata0, d0);
    check_eq({tag, " rvalid1 T+2"}, rvalid1, 1);
    check_eq({tag, " rdata1"}, rdata1, d1);
    check_eq({tag, " err1"}, err1, e1);
  endtask

  initial begin
    #1 rst = 1'b1;
    #1;
    check_reset_outputs("por");
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
    measure_init("por");

    // Zeroized contents; 511 is out of range for the 300-deep instance.
    issue(0, 0, 0, 0, 1, 9'd0);
    expect_read("rd0", 32'h0, 0, 32'h0, 0);
    issue(0, 0, 0, 0, 1, 9'd255);
    expect_read("rd255", 32'h0, 0, 32'h0, 0);
    issue(0, 0, 0, 0, 1, 9'd511);
    expect_read("rd511", 32'h0, 0, 32'h0, 1);

    // Masked writes
    issue(1, 9'd5, 32'hDEAD_BEEF, 32'hFFFF_FFFF, 0, 0);
    issue(1, 9'd5, 32'h0000_0000, 32'h0000_FF00, 0, 0);
    issue(0, 0, 0, 0, 1, 9'd5);
    expect_read("mask", 32'hDEAD_00EF, 0, 32'hDEAD_00EF, 0);
    issue(1, 9'd5, 32'hFFFF_FFFF, 32'h0, 0, 0);
    issue(0, 0, 0, 0, 1, 9'd5);
    expect_read("mask0", 32'hDEAD_00EF, 0, 32'hDEAD_00EF, 0);

    // Same-cycle write/read bypass, then independent addresses
    issue(1, 9'd9, 32'h1234_5678, 32'hFFFF_0000, 1, 9'd9);
    expect_read("bypass", 32'h1234_0000, 0, 32'h1234_0000, 0);
    issue(1, 9'd10, 32'hCAFE_F00D, 32'hFFFF_FFFF, 1, 9'd9);
    expect_read("diffaddr", 32'h1234_0000, 0, 32'h1234_0000, 0);
    issue(0, 0, 0, 0, 1, 9'd10);
    expect_read("rd10", 32'hCAFE_F00D, 0, 32'hCAFE_F00D, 0);

    // Range boundary: 310 is valid only in the 512-deep instance
    issue(1, 9'd299, 32'h0BAD_F00D, 32'hFFFF_FFFF, 0, 0);
    issue(1, 9'd310, 32'hA5A5_A5A5, 32'hFFFF_FFFF, 0, 0);
    issue(0, 0, 0, 0, 1, 9'd310);
    expect_read("rd310", 32'hA5A5_A5A5, 0, 32'h0, 1);
    issue(0, 0, 0, 0, 1, 9'd299);
    expect_read("rd299", 32'h0BAD_F00D, 0, 32'h0BAD_F00D, 0);
    issue(0, 0, 0, 0, 1, 9'd54);
    expect_read("rd54", 32'h0, 0, 32'h0, 0);

    // Back-to-back reads followed by re-zeroization
    rd_req  = 1'b1;
    rd_addr = 9'd5;
    @(posedge clk);
    #1;
    check_eq("b2b a rvalid0", rvalid0, 1);
    check_eq("b2b a rdata0", rdata0, 32'hDEAD_00EF);
    rd_addr = 9'd9;
    @(posedge clk);
    #1;
    check_eq("b2b b rdata0", rdata0, 32'h1234_0000);
    check_eq("b2b a rvalid1", rvalid1, 1);
    check_eq("b2b a rdata1", rdata1, 32'hDEAD_00EF);
    rd_addr = 9'd299;
    @(posedge clk);
    #1;
    check_eq("b2b c rdata0", rdata0, 32'h0BAD_F00D);
    check_eq("b2b b rdata1", rdata1, 32'h1234_0000);
    rd_req   = 1'b0;
    init_req = 1'b1;
    @(posedge clk);
    #1;
    init_req = 1'b0;
    check_eq("b2b end rvalid0", rvalid0, 0);
    check_eq("b2b c rvalid1", rvalid1, 1);
    check_eq("b2b c rdata1", rdata1, 32'h0BAD_F00D);
    measure_init("reinit");
    issue(0, 0, 0, 0, 1, 9'd5);
    expect_read("zero5", 32'h0, 0, 32'h0, 0);
    issue(0, 0, 0, 0, 1, 9'd299);
    expect_read("zero299", 32'h0, 0, 32'h0, 0);
    issue(0, 0, 0, 0, 1, 9'd310);
    expect_read("zero310", 32'h0, 0, 32'h0, 1);

    // Reset 100 cycles into INIT
    issue(1, 9'd7, 32'h55AA_55AA, 32'hFFFF_FFFF, 0, 0);
    issue(0, 0, 0, 0, 1, 9'd7);
    expect_read("rd7", 32'h55AA_55AA, 0, 32'h55AA_55AA, 0);
    init_req = 1'b1;
    @(posedge clk);
    #1;
    init_req = 1'b0;
    repeat (100) @(posedge clk);
    #1;
    check_eq("mid init busy0", busy0, 1);
    rst = 1'b1;
    #1;
    check_reset_outputs("midinit rst");
    @(posedge clk);
    #1;
    rst = 1'b0;
    measure_init("rerun");
    issue(0, 0, 0, 0, 1, 9'd7);
    expect_read("rd7 zero", 32'h0, 0, 32'h0, 0);

    // Reset with a read still in the second stage of the latency-2 instance
    issue(1, 9'd7, 32'h1357_9BDF, 32'hFFFF_FFFF, 0, 0);
    issue(0, 0, 0, 0, 1, 9'd7);
    check_eq("midread rdata0", rdata0, 32'h1357_9BDF);
    rst = 1'b1;
    #1;
    check_eq("midread rvalid1", rvalid1, 0);
    check_eq("midread rdata0 rst", rdata0, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;
    check_eq("midread dropped", rvalid1, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/rf_1r1w_be_ctrl.md
Name: rf_1r1w_be_ctrl

Overview:
Parametrised single-clock 1-read/1-write register file with per-bit write masks. It is the next generation of the fixed 512x32 bit-enable RF macro: width and depth are generic, and it adds a req/gnt/rvalid handshake, optional output pipeline register, same-cycle write-to-read bypass, out-of-range detection and a hardware zeroization FSM. It sits behind SoC-side memory adapters (scratch RAM, FIFO backing store) and is implemented as a behavioural flop array, so it is portable to any target.

Parameters:
Depth, 512, number of words; need not be a power of two; must be at least 2.
Width, 32, bits per word.
OutReg, 0, 0 gives read latency 1; 1 adds an output register for read latency 2.
InitOnReset, 1, 1 means zeroize all entries after reset; 0 means go straight to IDLE with contents undefined.
AddrW, $clog2(Depth), localparam; address width.

Ports:
clk_i  in  1  clock
rst_i  in  1  asynchronous active-high reset
wr_req_i  in  1  write request
wr_gnt_o  out  1  write accepted this cycle
wr_addr_i  in  AddrW  write address
wr_data_i  in  Width  write data
wr_mask_i  in  Width  per-bit write enable; 1 means update that bit
rd_req_i  in  1  read request
rd_gnt_o  out  1  read accepted this cycle
rd_addr_i  in  AddrW  read address
rd_rvalid_o  out  1  read data valid pulse
rd_data_o  out  Width  read data
rd_err_o  out  1  read address was out of range; valid with rd_rvalid_o
init_req_i  in  1  request re-zeroization
init_busy_o  out  1  zeroization in progress

Behaviour:
- Reset values (async on rst_i high):
  - wr_gnt_o=0, rd_gnt_o=0, rd_rvalid_o=0, rd_data_o=0, rd_err_o=0.
  - init_busy_o = InitOnReset.
  - FSM state = INIT if InitOnReset, else IDLE.
  - init counter = 0.
- FSM has two states, INIT and IDLE. The state is registered, and init_busy_o = (state==INIT).
- INIT:
  - Each cycle, write 0 to entry cnt, then cnt++.
  - When cnt==Depth-1, write that entry and go to IDLE next cycle. INIT therefore lasts exactly Depth cycles.
  - Both grants are held at 0. init_req_i is ignored.
- IDLE:
  - wr_gnt_o = wr_req_i; rd_gnt_o = rd_req_i. Both are combinational and depend only on the registered state.
  - init_req_i=1 moves the FSM to INIT next cycle with cnt=0. Requests presented in that same cycle are still granted and completed.
- Write: on a granted write with wr_addr_i<Depth, at the clock edge mem[a] <= (mem[a] & ~mask) | (data & mask).
  - mask=0 leaves the entry unchanged.
  - wr_addr_i>=Depth: the write is dropped with no side effect.
- Read: a read granted in cycle T gives rd_rvalid_o=1 for one cycle at T+1 (OutReg=0) or at T+2 (OutReg=1).
  - Back-to-back reads sustain one read per cycle.
- Read-during-write, same cycle and same in-range address: the read returns the merged post-write value (write-first). Different addresses are independent.
- Out-of-range read (rd_addr_i>=Depth): rd_data_o=0 and rd_err_o=1, both aligned with rd_rvalid_o.
- rd_data_o holds its last value while rd_rvalid_o=0. rd_err_o is 0 whenever rd_rvalid_o=0.
- Reads already in the pipeline when INIT begins still complete and return pre-zeroization data. Zeroization of an entry starts at the first INIT cycle.
- Reset asserted mid-INIT restarts INIT from cnt=0 once deasserted. Reset mid-read drops the pending rvalid.
- Counter width is AddrW, with no wrap past Depth-1. Zeroization writes happen only in INIT; user writes happen only in IDLE, so the two never collide.

Decomposition:
- Shared package rf_pkg holds:
  - rf_state_e {RfInit, RfIdle} (1-bit enum);
  - a function computing merged data from old, new and mask, reused for both the write path and the bypass path.
- One sub-module, rf_1r1w_be_ctrl_rdpipe, holds the rvalid/data/err pipeline stage(s), selected by OutReg.
- The storage array, FSM and bypass logic stay in the top.

Test Plan:
1. Reset with InitOnReset=1, Depth=512. Required: init_busy_o=1 for exactly 512 cycles, grants 0 throughout. Then read addresses 0, 255 and 511: each returns 0x00000000 with rd_err_o=0.
2. Write addr 5 data 0xDEADBEEF mask 0xFFFFFFFF, then addr 5 data 0x00000000 mask 0x0000FF00. Reading addr 5 must return 0xDEAD00EF, at T+1 with OutReg=0 and at T+2 with OutReg=1.
3. Same cycle: write addr 9 data 0x12345678 mask 0xFFFF0000 (old value 0) and read addr 9. Required: rd_data_o=0x12340000.
4. Depth=300: write addr 310, then read addr 310 and read addr 299. Required: 310 returns 0x0 with rd_err_o=1; memory is unchanged; 299 returns its stored value with rd_err_o=0.
5. Issue 3 back-to-back reads, then init_req_i in the cycle after the last grant. Required: all 3 rvalids arrive with pre-init data, then init_busy_o stays high for Depth cycles, and afterwards all entries read 0.
6. Assert rst_i at cycle 100 of INIT. Required: all outputs return to reset values, and INIT reruns for the full Depth cycles before the first grant.
